// File: rtl/riscv_lsu.sv
// riscv_lsu -- load/store unit for the MEM stage.
//
// Turns a MEM-stage load/store into a multi-cycle req/ack data-memory access
// with byte enables, extracts and extends load data from its byte lane, and
// aborts an access that sees no acknowledge within TIMEOUT cycles. stall_o
// holds the pipeline while an access is outstanding.
//
// Parameters
//   DW       datapath width, 32 or 64 (NB = DW/8 byte lanes)
//   TIMEOUT  BUSY cycles without dmem_ack_i before abort; 0 = never
//
// Build option
//   RISCV_LSU_MISALIGN_TRAP_EN  defined: misaligned accesses complete at once
//     with misalign_o=1 and no memory access. Undefined: the low address bits
//     below the access size are dropped and misalign_o is always 0.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i/we/funct3/addr/wdata  request from the MEM stage
//   stall_o                       hold PC and IF/ID..EX/MEM
//   rsp_valid_o/rdata/err/misalign    one-cycle completion response
//   dmem_addr/wdata/be/rd_en/wr_en    data-memory request (held until ack)
//   dmem_ack_i, dmem_rdata_i      data-memory completion and read data
module riscv_lsu #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   input  logic            req_we_i,
   input  logic [2:0]      req_funct3_i,
   input  logic [DW-1:0]   req_addr_i,
   input  logic [DW-1:0]   req_wdata_i,
   output logic            stall_o,
   output logic            rsp_valid_o,
   output logic [DW-1:0]   rsp_rdata_o,
   output logic            err_o,
   output logic            misalign_o,
   output logic [DW-1:0]   dmem_addr_o,
   output logic [DW-1:0]   dmem_wdata_o,
   output logic [DW/8-1:0] dmem_be_o,
   output logic            dmem_rd_en_o,
   output logic            dmem_wr_en_o,
   input  logic            dmem_ack_i,
   input  logic [DW-1:0]   dmem_rdata_i
);

   localparam int NB = DW / 8;
   localparam int OB = $clog2(NB);
   localparam int LW = $clog2(DW);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_we, r_uns, r_err, r_mis, r_rd_en, r_wr_en;
   logic [1:0]      r_size;
   logic [OB-1:0]   r_off;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_rdata, r_addr, r_wdata;
   logic [NB-1:0]   r_be;

   logic            w_legal, w_mis, w_trap, w_sign, w_timeout;
   logic [OB-1:0]   w_off, w_amask, w_off_eff;
   logic [NB-1:0]   w_be_base, w_be;
   logic [DW-1:0]   w_wdata, w_shifted, w_ext;
   logic [31:0]     w_msb;

   // Request decode: size, legality, alignment, lane placement.
   always_comb begin
      w_off = req_addr_i[OB-1:0];
      case (req_funct3_i[1:0])
         2'd0:    begin w_amask = '0;      w_be_base = NB'(1);   end
         2'd1:    begin w_amask = OB'(1);  w_be_base = NB'(3);   end
         2'd2:    begin w_amask = OB'(3);  w_be_base = NB'(15);  end
         default: begin w_amask = OB'(7);  w_be_base = NB'(255); end
      endcase
      case (req_funct3_i)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
         3'b011, 3'b110:                          w_legal = (DW == 64);
         default:                                 w_legal = 1'b0;
      endcase
      w_mis = |(w_off & w_amask);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      w_trap = w_mis;
`else
      w_trap = 1'b0;
`endif
      // Aligned accesses are unaffected; untrapped misaligned ones drop the low bits.
      w_off_eff = w_off & ~w_amask;
      w_be      = w_be_base << w_off_eff;
      // Lane i takes source byte (i mod size), replicating the datum in every lane.
      for (int unsigned i = 0; i < NB; i++) begin
         w_wdata[i*8 +: 8] = req_wdata_i[{(OB'(i) & w_amask), 3'b000} +: 8];
      end
   end

   // Load extraction: shift the lane down, keep size bits, extend from the top kept bit.
   always_comb begin
      w_shifted = dmem_rdata_i >> {r_off, 3'b000};
      case (r_size)
         2'd0:    w_msb = 32'd7;
         2'd1:    w_msb = 32'd15;
         2'd2:    w_msb = 32'd31;
         default: w_msb = 32'(DW - 1);
      endcase
      w_sign = ~r_uns & w_shifted[w_msb[LW-1:0]];
      for (int unsigned i = 0; i < DW; i++) begin
         w_ext[i] = (i <= w_msb) ? w_shifted[i] : w_sign;
      end
   end

   // r_cnt holds completed BUSY cycles, so the abort happens in the TIMEOUT-th one.
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      stall_o     = 1'b0;
      rsp_valid_o = 1'b0;
      rsp_rdata_o = '0;
      err_o       = 1'b0;
      misalign_o  = 1'b0;
      case (r_state)
         S_IDLE: begin
            stall_o = req_valid_i;
            if (req_valid_i) w_state_nxt = (!w_legal || w_trap) ? S_DONE : S_BUSY;
         end
         S_BUSY: begin
            stall_o = 1'b1;
            if (dmem_ack_i || w_timeout) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            rsp_valid_o = 1'b1;
            rsp_rdata_o = r_rdata;
            err_o       = r_err;
            misalign_o  = r_mis;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_size  <= '0;
         r_off   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_mis   <= 1'b0;
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_we    <= req_we_i;
                  r_uns   <= req_funct3_i[2];
                  r_size  <= req_funct3_i[1:0];
                  r_off   <= w_off_eff;
                  r_cnt   <= '0;
                  r_rdata <= '0;
                  r_err   <= ~w_legal;
                  r_mis   <= w_legal & w_trap;
                  if (w_legal && !w_trap) begin
                     r_rd_en <= ~req_we_i;
                     r_wr_en <= req_we_i;
                     r_addr  <= {req_addr_i[DW-1:OB], {OB{1'b0}}};
                     r_wdata <= w_wdata;
                     r_be    <= w_be;
                  end
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (dmem_ack_i) begin
                  r_rd_en <= 1'b0;
                  r_wr_en <= 1'b0;
                  r_rdata <= r_we ? '0 : w_ext;
               end else if (w_timeout) begin
                  r_rd_en <= 1'b0;
                  r_wr_en <= 1'b0;
                  r_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_addr_o  = r_addr;
   assign dmem_wdata_o = r_wdata;
   assign dmem_be_o    = r_be;
   assign dmem_rd_en_o = r_rd_en;
   assign dmem_wr_en_o = r_wr_en;

endmodule
